// File: rtl/param_operand_stack.sv
// Parametrised operand stack with combinational TOS/NOS ports and a sticky FAULT state.
// Optional high-water mark output (hwm/hwm_clr) is built when STACK_HWM_EN is defined.
module param_operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [1:0]       sp_op,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             err_clr,
`ifdef STACK_HWM_EN
  input  logic             hwm_clr,
  output logic [CW-1:0]    hwm,
`endif
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic             fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);
  localparam logic [CW-1:0] THREE = CW'(3);

  typedef enum logic {RUN, FAULT} state_t;

  state_t                      state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [CW-1:0]               count_q, new_cnt;
  logic                        legal, do_op, ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0]               wr_idx, tos_idx, nos_idx;

  // Legality and post-operation occupancy, using the pre-operation count
  always_comb begin
    legal   = 1'b0;
    new_cnt = count_q;
    unique case (sp_op)
      2'b11: begin legal = count_q < DEPTH_C;                            new_cnt = count_q + ONE; end
      2'b10: begin legal = !wr_en || count_q >= ONE;                     new_cnt = count_q;       end
      2'b01: begin legal = count_q >= (wr_en ? TWO : ONE);              new_cnt = count_q - ONE; end
      2'b00: begin legal = count_q >= (wr_en ? THREE : TWO);            new_cnt = count_q - TWO; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    do_op   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (op_valid) begin
          if (legal) begin
            do_op = 1'b1;
          end else begin
            state_d = FAULT;
            if (sp_op == 2'b11) ovf_d = 1'b1;
            else                unf_d = 1'b1;
          end
        end
      end
      FAULT: begin
        // Operations are dropped while faulted, even alongside err_clr
        if (err_clr) begin
          state_d = RUN;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
    endcase
  end

  assign wr_idx = AW'(new_cnt - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      count_q <= '0;
      mem     <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (do_op) begin
        count_q <= new_cnt;
        if (wr_en) mem[wr_idx] <= wr_data;
      end
    end
  end

`ifdef STACK_HWM_EN
  logic [CW-1:0] hwm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            hwm_q <= '0;
    else if (hwm_clr)                      hwm_q <= count_q;
    else if (do_op && new_cnt > hwm_q)     hwm_q <= new_cnt;
  end
  assign hwm = hwm_q;
`endif

  assign tos_idx = AW'(count_q - ONE);
  assign nos_idx = AW'(count_q - TWO);

  assign tos           = (count_q >= ONE) ? mem[tos_idx] : '0;
  assign nos           = (count_q >= TWO) ? mem[nos_idx] : '0;
  assign count         = count_q;
  assign full          = count_q == DEPTH_C;
  assign empty         = count_q == '0;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign fault         = state_q == FAULT;

endmodule

// File: tb/tb_param_operand_stack.sv
// Scoreboard bench for param_operand_stack: stimulus pushes model predictions, a monitor
// pops and compares after each rising edge. hwm is checked when STACK_HWM_EN is defined.
module tb_param_operand_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, wr_en = 1'b0, err_clr = 1'b0;
  logic [1:0] sp_op = 2'b10;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0] count;
  logic full, empty, overflow_err, underflow_err, fault;
`ifdef STACK_HWM_EN
  logic hwm_clr = 1'b0;
  logic [CW-1:0] hwm;
`endif

  param_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .sp_op(sp_op), .wr_en(wr_en),
    .wr_data(wr_data), .err_clr(err_clr),
`ifdef STACK_HWM_EN
    .hwm_clr(hwm_clr), .hwm(hwm),
`endif
    .tos(tos), .nos(nos), .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    logic [WIDTH-1:0] tos, nos;
    bit full, empty, ovf, unf, flt;
    int hwm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int n_pass = 0, n_total = 0;

  // Reference model: an array of entries plus an occupancy count
  int m_cnt, m_hwm;
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit m_flt, m_ovf, m_unf;

  task automatic check(string name, bit ok, string act, string req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %s required %s", name, act, req);
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_hwm = 0; m_flt = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endfunction

  function automatic void model_step(bit v, logic [1:0] op, bit we, logic [WIDTH-1:0] d, bit clr);
    int n, nc;
    bit ok;
    n = m_cnt; nc = n; ok = 0;
    if (m_flt) begin
      if (clr) begin m_flt = 0; m_ovf = 0; m_unf = 0; end
      return;
    end
    if (!v) return;
    case (op)
      2'b11: begin ok = n < DEPTH;             nc = n + 1; end
      2'b10: begin ok = !we || n >= 1;         nc = n;     end
      2'b01: begin ok = n >= (we ? 2 : 1);     nc = n - 1; end
      default: begin ok = n >= (we ? 3 : 2);   nc = n - 2; end
    endcase
    if (!ok) begin
      m_flt = 1;
      if (op == 2'b11) m_ovf = 1; else m_unf = 1;
      return;
    end
    if (we) m_mem[nc-1] = d;
    m_cnt = nc;
    if (nc > m_hwm) m_hwm = nc;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt   = m_cnt;
    e.tos   = (m_cnt >= 1) ? m_mem[m_cnt-1] : '0;
    e.nos   = (m_cnt >= 2) ? m_mem[m_cnt-2] : '0;
    e.full  = m_cnt == DEPTH;
    e.empty = m_cnt == 0;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.flt   = m_flt;
    e.hwm   = m_hwm;
    return e;
  endfunction

  task automatic issue(string name, bit v, logic [1:0] op, bit we, logic [WIDTH-1:0] d, bit clr);
    @(negedge clk);
    op_valid = v; sp_op = op; wr_en = we; wr_data = d; err_clr = clr;
    model_step(v, op, we, d, clr);
    exp_q.push_back(snapshot());
    name_q.push_back(name);
  endtask

  // Monitor: one prediction is consumed per rising edge while any are pending
  initial begin
    exp_t e;
    string nm, act, req;
    bit ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        ok = count == e.cnt && tos == e.tos && nos == e.nos && full == e.full &&
             empty == e.empty && overflow_err == e.ovf && underflow_err == e.unf && fault == e.flt;
        act = $sformatf("cnt=%0d tos=%h nos=%h full=%b empty=%b ovf=%b unf=%b flt=%b",
                        count, tos, nos, full, empty, overflow_err, underflow_err, fault);
        req = $sformatf("cnt=%0d tos=%h nos=%h full=%b empty=%b ovf=%b unf=%b flt=%b",
                        e.cnt, e.tos, e.nos, e.full, e.empty, e.ovf, e.unf, e.flt);
`ifdef STACK_HWM_EN
        ok  = ok && hwm == e.hwm;
        act = {act, $sformatf(" hwm=%0d", hwm)};
        req = {req, $sformatf(" hwm=%0d", e.hwm)};
`endif
        check(nm, ok, act, req);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("reset_state", 0, 2'b00, 1, 8'hFF, 0);

    // Push three, ALU-style DES_1 with write, then DES_2 to empty
    issue("t1_push", 1, 2'b11, 1, 8'h11, 0);
    issue("t1_push", 1, 2'b11, 1, 8'h22, 0);
    issue("t1_push", 1, 2'b11, 1, 8'h33, 0);
    issue("t2_alu",  1, 2'b01, 1, 8'h55, 0);
    issue("t2_des2", 1, 2'b00, 0, 8'h00, 0);

    // Fill to full, overflow, frozen while faulted, then clear
    for (int i = 0; i < DEPTH; i++) issue("t3_fill", 1, 2'b11, 1, WIDTH'(8'hA0 + i), 0);
    issue("t3_ovf",    1, 2'b11, 1, 8'hEE, 0);
    issue("t3_frozen", 1, 2'b01, 0, 8'h00, 0);
    issue("t3_clr",    0, 2'b10, 0, 8'h00, 1);

    // Down to two, illegal DES_2+wr, clear with a dropped ADV_1
    for (int i = 0; i < 7; i++) issue("t4_pop", 1, 2'b00, 0, 8'h00, 0);
    issue("t4_unf",    1, 2'b00, 1, 8'h99, 0);
    issue("t4_clr_op", 1, 2'b11, 1, 8'h77, 1);

    // ADV_0 overwrite at count 1, illegal ADV_0+wr at count 0
    issue("t5_pop",    1, 2'b01, 0, 8'h00, 0);
    issue("t5_adv0",   1, 2'b10, 1, 8'h7E, 0);
    issue("t5_pop",    1, 2'b01, 0, 8'h00, 0);
    issue("t5_adv0_e", 1, 2'b10, 1, 8'h42, 0);
    issue("t5_clr",    0, 2'b00, 0, 8'h00, 1);
    issue("t5_rstale", 1, 2'b11, 0, 8'h00, 0);
    issue("t5_pop",    1, 2'b01, 0, 8'h00, 0);

    // Asynchronous reset with five entries on the stack
    for (int i = 0; i < 5; i++) issue("t6_push", 1, 2'b11, 1, WIDTH'(8'hC0 + i), 0);
    @(negedge clk);
    op_valid = 1'b0; wr_en = 1'b0; err_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("t6_async_rst", count == 0 && tos == 0 && fault == 0 && empty == 1,
             $sformatf("cnt=%0d tos=%h flt=%b empty=%b", count, tos, fault, empty),
             "cnt=0 tos=00 flt=0 empty=1");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue("t6_after_rst", 0, 2'b11, 1, 8'h12, 0);
    for (int i = 0; i < 5; i++) issue("t6_push2", 1, 2'b11, 1, WIDTH'(8'hD0 + i), 0);
    issue("t6_pop", 1, 2'b01, 0, 8'h00, 0);
    issue("t6_pop", 1, 2'b01, 0, 8'h00, 0);

    // Randomised traffic, biased towards valid operations
    for (int i = 0; i < 600; i++) begin
      issue("rand", $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            WIDTH'($urandom), $urandom_range(0, 3) == 0);
    end

    issue("idle", 0, 2'b00, 0, 8'h00, 0);
    repeat (3) @(negedge clk);
    check("drain", exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
